// File: rtl/sr_cmd_sequencer.sv
// sr_cmd_sequencer
//   Queues drive commands for a downstream SR flip-flop and plays them out as
//   registered S/R pulses, each held for a programmable number of cycles.
//   A one-cycle S=R=0 gap is inserted whenever the drive flips directly
//   between SET and RESET (break-before-make), so S and R are never both high.
//
// Ports
//   clk        sole clock, rising edge
//   rst        synchronous active-high reset (overrides abort and handshakes)
//   cmd_valid  command offered            cmd_ready  FIFO has room (level != DEPTH)
//   cmd_op     00 HOLD 01 SET 10 RESET 11 TOGGLE
//   cmd_len    hold length in cycles, 0 behaves as 1
//   abort      flush FIFO, return to IDLE, drop any command offered that edge
//   q_fb       flip-flop Q, only used to resolve TOGGLE at pop time
//   S, R       registered set/reset drive
//   busy       FSM not IDLE or FIFO non-empty
//   level      FIFO occupancy
//   dbg_state  current FSM state (0 IDLE, 1 DRIVE, 2 GAP)
//
// Handshake: a command transfers on every rising edge where cmd_valid and
// cmd_ready are both high; cmd_ready never looks at cmd_valid, and a
// transfer on an abort or rst edge is discarded.
//
// DEPTH must be a power of two and at least 2.
module sr_cmd_sequencer #(
   parameter int DEPTH = 4,
   parameter int LEN_W = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic [1:0]               cmd_op,
   input  logic [LEN_W-1:0]         cmd_len,
   input  logic                     abort,
   input  logic                     q_fb,
   output logic                     S,
   output logic                     R,
   output logic                     busy,
   output logic [$clog2(DEPTH):0]   level,
   output logic [1:0]               dbg_state
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

   localparam logic [1:0] OP_HOLD   = 2'd0;
   localparam logic [1:0] OP_SET    = 2'd1;
   localparam logic [1:0] OP_RESET  = 2'd2;
   localparam logic [1:0] OP_TOGGLE = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRIVE = 2'd1,
      ST_GAP   = 2'd2
   } state_e;

   state_e               state_q, state_d;
   logic [LEN_W-1:0]     cnt_q, cnt_d;
   logic [1:0]           op_q, op_d;      // resolved op currently driven / pending after GAP
   logic                 s_q, s_d, r_q, r_d;
   logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]          level_q, level_d;
   logic [LEN_W+1:0]     mem_q [DEPTH];

   logic                 push, pop;
   logic [LEN_W+1:0]     head;
   logic [1:0]           head_op, head_res;
   logic [LEN_W-1:0]     head_len, head_cnt;
   logic                 opposite;

   assign cmd_ready = (level_q != FULL_LVL);
   assign push      = cmd_valid && cmd_ready;

   assign head     = mem_q[rd_ptr_q];
   assign head_op  = head[LEN_W+1:LEN_W];
   assign head_len = head[LEN_W-1:0];
   // TOGGLE becomes a concrete SET/RESET using Q as seen on the pop edge.
   assign head_res = (head_op == OP_TOGGLE) ? (q_fb ? OP_RESET : OP_SET) : head_op;
   assign head_cnt = (head_len == '0) ? LEN_W'(1) : head_len;
   assign opposite = ((op_q == OP_SET)   && (head_res == OP_RESET)) ||
                     ((op_q == OP_RESET) && (head_res == OP_SET));

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      s_d     = s_q;
      r_d     = r_q;
      pop     = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            s_d = 1'b0;
            r_d = 1'b0;
            if (level_q != '0) begin
               pop     = 1'b1;
               state_d = ST_DRIVE;
               op_d    = head_res;
               cnt_d   = head_cnt;
               s_d     = (head_res == OP_SET);
               r_d     = (head_res == OP_RESET);
            end
         end
         ST_DRIVE: begin
            // Counter never sits at 0 in DRIVE; <= keeps a stray 0 from wrapping.
            if (cnt_q <= LEN_W'(1)) begin
               if (level_q != '0) begin
                  pop   = 1'b1;
                  op_d  = head_res;
                  cnt_d = head_cnt;
                  if (opposite) begin
                     state_d = ST_GAP;
                     s_d     = 1'b0;
                     r_d     = 1'b0;
                  end else begin
                     state_d = ST_DRIVE;
                     s_d     = (head_res == OP_SET);
                     r_d     = (head_res == OP_RESET);
                  end
               end else begin
                  state_d = ST_IDLE;
                  op_d    = OP_HOLD;
                  s_d     = 1'b0;
                  r_d     = 1'b0;
               end
            end else begin
               cnt_d = cnt_q - LEN_W'(1);
            end
         end
         ST_GAP: begin
            // op_q/cnt_q already hold the command popped on GAP entry.
            state_d = ST_DRIVE;
            s_d     = (op_q == OP_SET);
            r_d     = (op_q == OP_RESET);
         end
         default: begin
            state_d = ST_IDLE;
            s_d     = 1'b0;
            r_d     = 1'b0;
         end
      endcase

      if (abort) begin
         state_d = ST_IDLE;
         op_d    = OP_HOLD;
         cnt_d   = '0;
         s_d     = 1'b0;
         r_d     = 1'b0;
         pop     = 1'b0;
      end
   end

   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
      level_d  = level_q;
      unique case ({push, pop})
         2'b10:   level_d = level_q + (AW+1)'(1);
         2'b01:   level_d = level_q - (AW+1)'(1);
         default: level_d = level_q;
      endcase
      if (abort) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         op_q     <= OP_HOLD;
         s_q      <= 1'b0;
         r_q      <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         op_q     <= op_d;
         s_q      <= s_d;
         r_q      <= r_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // Storage needs no reset: entries are only read below level_q.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= {cmd_op, cmd_len};
      end
   end

   assign S         = s_q;
   assign R         = r_q;
   assign level     = level_q;
   assign busy      = (state_q != ST_IDLE) || (level_q != '0);
   assign dbg_state = state_q;

endmodule

// File: tb/tb_sr_cmd_sequencer.sv
module tb_sr_cmd_sequencer;

   localparam logic [1:0] HOLD   = 2'd0;
   localparam logic [1:0] SET    = 2'd1;
   localparam logic [1:0] RESET  = 2'd2;
   localparam logic [1:0] TOGGLE = 2'd3;

   logic       clk = 1'b0;
   logic       rst;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [1:0] cmd_op;
   logic [3:0] cmd_len;
   logic       abort;
   logic       q_fb;
   logic       sig_s;
   logic       sig_r;
   logic       busy;
   logic [2:0] level;
   logic [1:0] dbg_state;

   int n_tests = 0;
   int n_fail  = 0;

   sr_cmd_sequencer #(.DEPTH(4), .LEN_W(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_len   (cmd_len),
      .abort     (abort),
      .q_fb      (q_fb),
      .S         (sig_s),
      .R         (sig_r),
      .busy      (busy),
      .level     (level),
      .dbg_state (dbg_state)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish, expected finish");
      $fatal(1, "watchdog");
   end

   // ---------------- helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_sr(input string tag, input logic s_exp, input logic r_exp);
      check({tag, "_S"}, 32'(sig_s), 32'(s_exp));
      check({tag, "_R"}, 32'(sig_r), 32'(r_exp));
      check({tag, "_excl"}, 32'(sig_s & sig_r), 32'd0);
   endtask

   task automatic set_cmd(input logic [1:0] op, input logic [3:0] len);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_len   = len;
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_len = 4'd0; abort = 1'b0; q_fb = 1'b0;
      tick(); tick();
      rst = 1'b0;
      check_sr("rst", 1'b0, 1'b0);
      check("rst_level", 32'(level), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_ready", 32'(cmd_ready), 32'd1);
      check("rst_state", 32'(dbg_state), 32'd0);

      // SET len=3 while idle: S high for exactly 3 cycles, 1 cycle after accept
      set_cmd(SET, 4'd3); tick(); cmd_valid = 1'b0;
      check_sr("s1_acc", 1'b0, 1'b0);
      check("s1_acc_level", 32'(level), 32'd1);
      check("s1_acc_busy", 32'(busy), 32'd1);
      tick(); check_sr("s1_c1", 1'b1, 1'b0); check("s1_c1_level", 32'(level), 32'd0);
      tick(); check_sr("s1_c2", 1'b1, 1'b0);
      tick(); check_sr("s1_c3", 1'b1, 1'b0);
      tick(); check_sr("s1_end", 1'b0, 1'b0); check("s1_end_busy", 32'(busy), 32'd0);

      // SET 2 then RESET 2 back-to-back: one GAP cycle between them
      set_cmd(SET, 4'd2); tick();
      check_sr("s2_acc", 1'b0, 1'b0);
      set_cmd(RESET, 4'd2); tick(); cmd_valid = 1'b0;
      check_sr("s2_set1", 1'b1, 1'b0); check("s2_set1_level", 32'(level), 32'd1);
      tick(); check_sr("s2_set2", 1'b1, 1'b0);
      tick(); check_sr("s2_gap", 1'b0, 1'b0); check("s2_gap_state", 32'(dbg_state), 32'd2);
      tick(); check_sr("s2_rst1", 1'b0, 1'b1);
      tick(); check_sr("s2_rst2", 1'b0, 1'b1);
      tick(); check_sr("s2_end", 1'b0, 1'b0); check("s2_end_busy", 32'(busy), 32'd0);

      // SET 2, HOLD 1, SET 1: no GAP inserted around HOLD
      set_cmd(SET, 4'd2); tick();
      set_cmd(HOLD, 4'd1); tick();
      check_sr("s3_set1", 1'b1, 1'b0);
      set_cmd(SET, 4'd1); tick(); cmd_valid = 1'b0;
      check_sr("s3_set2", 1'b1, 1'b0); check("s3_level", 32'(level), 32'd2);
      tick(); check_sr("s3_hold", 1'b0, 1'b0); check("s3_hold_state", 32'(dbg_state), 32'd1);
      tick(); check_sr("s3_set3", 1'b1, 1'b0);
      tick(); check_sr("s3_end", 1'b0, 1'b0); check("s3_end_busy", 32'(busy), 32'd0);

      // TOGGLE len=1 resolved by q_fb at pop
      q_fb = 1'b1;
      set_cmd(TOGGLE, 4'd1); tick(); cmd_valid = 1'b0;
      tick(); check_sr("s4_tog_q1", 1'b0, 1'b1);
      tick(); check_sr("s4_tog_q1_end", 1'b0, 1'b0);
      q_fb = 1'b0;
      set_cmd(TOGGLE, 4'd1); tick(); cmd_valid = 1'b0;
      tick(); check_sr("s4_tog_q0", 1'b1, 1'b0);
      tick(); check_sr("s4_tog_q0_end", 1'b0, 1'b0);

      // Fill FIFO behind a len=15 SET; 5th command held off until room frees
      set_cmd(SET, 4'd15); tick(); cmd_valid = 1'b0;
      tick(); check_sr("s5_long", 1'b1, 1'b0);                        // edge B
      set_cmd(HOLD, 4'd1);  tick();
      set_cmd(SET, 4'd2);   tick();
      set_cmd(HOLD, 4'd0);  tick();
      set_cmd(RESET, 4'd1); tick();                                   // edge B+4
      check("s5_full_level", 32'(level), 32'd4);
      check("s5_full_ready", 32'(cmd_ready), 32'd0);
      set_cmd(SET, 4'd1);                                             // 5th, held
      for (int i = 0; i < 3; i++) begin                               // B+5..B+7
         tick();
         check("s5_hold_level", 32'(level), 32'd4);
         check("s5_hold_ready", 32'(cmd_ready), 32'd0);
      end
      for (int i = 0; i < 7; i++) begin                               // B+8..B+14
         tick();
         check_sr("s5_long_run", 1'b1, 1'b0);
      end
      tick();                                                         // B+15 pop c1 HOLD
      check_sr("s5_c1_hold", 1'b0, 1'b0);
      check("s5_c1_level", 32'(level), 32'd3);
      check("s5_c1_ready", 32'(cmd_ready), 32'd1);
      tick(); cmd_valid = 1'b0;                                       // B+16 accept c5, pop c2
      check_sr("s5_c2_a", 1'b1, 1'b0); check("s5_c2_level", 32'(level), 32'd3);
      tick(); check_sr("s5_c2_b", 1'b1, 1'b0);
      tick(); check_sr("s5_c3_hold0", 1'b0, 1'b0); check("s5_c3_level", 32'(level), 32'd2);
      tick(); check_sr("s5_c4_reset", 1'b0, 1'b1);
      tick(); check_sr("s5_c5_gap", 1'b0, 1'b0); check("s5_gap_state", 32'(dbg_state), 32'd2);
      tick(); check_sr("s5_c5_set", 1'b1, 1'b0);
      tick(); check_sr("s5_end", 1'b0, 1'b0); check("s5_end_busy", 32'(busy), 32'd0);

      // abort mid-DRIVE with level=3, with a push offered on the abort edge
      set_cmd(SET, 4'd15); tick(); cmd_valid = 1'b0;
      tick();
      set_cmd(HOLD, 4'd1); tick();
      set_cmd(SET, 4'd1); tick();
      set_cmd(RESET, 4'd1); tick();
      check("s6_pre_level", 32'(level), 32'd3); check_sr("s6_pre", 1'b1, 1'b0);
      abort = 1'b1; set_cmd(SET, 4'd5); tick();
      abort = 1'b0; cmd_valid = 1'b0;
      check_sr("s6_abort", 1'b0, 1'b0);
      check("s6_abort_level", 32'(level), 32'd0);
      check("s6_abort_busy", 32'(busy), 32'd0);
      check("s6_abort_state", 32'(dbg_state), 32'd0);
      tick(); check("s6_discard_level", 32'(level), 32'd0); check_sr("s6_idle", 1'b0, 1'b0);
      set_cmd(SET, 4'd1); tick(); cmd_valid = 1'b0;
      check("s6_new_level", 32'(level), 32'd1);
      tick(); check_sr("s6_new", 1'b1, 1'b0);
      tick(); check_sr("s6_new_end", 1'b0, 1'b0); check("s6_new_busy", 32'(busy), 32'd0);

      // rst mid-DRIVE with level=3, overriding abort and a push
      set_cmd(RESET, 4'd15); tick(); cmd_valid = 1'b0;
      tick();
      set_cmd(SET, 4'd1); tick();
      set_cmd(HOLD, 4'd1); tick();
      set_cmd(SET, 4'd2); tick();
      check("s7_pre_level", 32'(level), 32'd3); check_sr("s7_pre", 1'b0, 1'b1);
      rst = 1'b1; abort = 1'b1; set_cmd(SET, 4'd5); tick();
      rst = 1'b0; abort = 1'b0; cmd_valid = 1'b0;
      check_sr("s7_rst", 1'b0, 1'b0);
      check("s7_rst_level", 32'(level), 32'd0);
      check("s7_rst_busy", 32'(busy), 32'd0);
      check("s7_rst_ready", 32'(cmd_ready), 32'd1);
      set_cmd(SET, 4'd1); tick(); cmd_valid = 1'b0;
      check("s7_new_level", 32'(level), 32'd1);
      tick(); check_sr("s7_new", 1'b1, 1'b0);
      tick(); check_sr("s7_new_end", 1'b0, 1'b0); check("s7_new_busy", 32'(busy), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
